// File: rtl/serial_frame_tx.sv
// serial_frame_tx: takes parallel words over a valid/ready handshake and
// shifts them out one bit per clock on x. When no word is in flight, x
// carries IDLE_BIT. words_sent counts fully transmitted words.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no word in flight, x = IDLE_BIT, ready for a new word
// ST_SHIFT | shifting a word out, x = head of shift register
//
// In ST_SHIFT with bitcnt == WIDTH-1 the last bit is on x. A new word may
// be accepted on that same edge, so back-to-back words have no idle gap.
module serial_frame_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b1,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int unsigned   BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic             at_last;
    logic             accept;

    assign at_last    = (state == ST_SHIFT) && (bitcnt == LAST);
    assign data_ready = !rst && ((state == ST_IDLE) || at_last);
    assign accept     = data_valid && data_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (at_last) begin
                    state_nxt = accept ? ST_SHIFT : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift register and bit counter: load on accept, otherwise shift toward the head
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (accept) begin
            shreg  <= data_in;
            bitcnt <= '0;
        end else if ((state == ST_SHIFT) && !at_last) begin
            if (MSB_FIRST) begin
                shreg <= shreg << 1;
            end else begin
                shreg <= shreg >> 1;
            end
            bitcnt <= bitcnt + BW'(1);
        end
    end

    // Completed-word counter, bumps on every last-bit edge and wraps freely
    always_ff @(posedge clk) begin
        if (rst) begin
            words_sent <= '0;
        end else if (at_last) begin
            words_sent <= words_sent + CNT_W'(1);
        end
    end

    // Output decode from registered state only
    always_comb begin
        x       = IDLE_BIT;
        x_valid = 1'b0;
        busy    = 1'b0;
        if (state == ST_SHIFT) begin
            x       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            x_valid = 1'b1;
            busy    = 1'b1;
        end
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Upstream feeder for the serial pattern detector: accepts parallel words over a valid/ready handshake and serializes them onto the single-bit line `x` the detector samples each `clk`.
- When no word is in flight, it drives a parameterized idle level. The default idle level of 1 holds the detector in its IDLE state.
- Keeps a wrapping count of fully transmitted words, so the bench can cross-check against the detector's user count.

Parameters:
- WIDTH, 8, bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = transmit data_in[WIDTH-1] first; 0 = transmit data_in[0] first.
- IDLE_BIT, 1'b1, level driven on x when not shifting.
- CNT_W, 10, width of words_sent.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  word to transmit; sampled on an accept edge.
- data_valid  in  1  producer has a word on data_in.
- data_ready  out  1  block can accept a word this cycle.
- x  out  1  serial bit to the detector.
- x_valid  out  1  high while x carries a data bit (not idle fill).
- busy  out  1  high in SHIFT state.
- words_sent  out  CNT_W  count of completed words, wraps modulo 2^CNT_W.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high, named `rst`; clock named `clk`.
  - At the reset edge: state=IDLE, shift register=0, bit counter=0, words_sent=0.
  - While rst is high: data_ready=0.
  - After reset: x=IDLE_BIT, x_valid=0, busy=0.
- States: IDLE, SHIFT. bitcnt counts 0..WIDTH-1.
- Accept: occurs at any rising edge where data_valid && data_ready && !rst.
- Readiness: data_ready = !rst && (state==IDLE || (state==SHIFT && bitcnt==WIDTH-1)). It is combinational from state and counter, and does not depend on data_valid.
- IDLE:
  - x=IDLE_BIT, x_valid=0.
  - On accept: load shift register with data_in, bitcnt<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - x = shift register head bit (MSB if MSB_FIRST, else LSB); x_valid=1.
  - Each edge with bitcnt<WIDTH-1: shift toward the head by one and bitcnt++.
- Last bit (SHIFT, bitcnt==WIDTH-1):
  - words_sent increments at this edge.
  - If accept also occurs: reload data_in, bitcnt<=0, stay in SHIFT. There is no idle gap between back-to-back words.
  - Otherwise go to IDLE.
- Latency: for a word accepted at edge N, bit 0 of the transmit order appears on x in the cycle after edge N. The last bit appears in the cycle after edge N+WIDTH-1. Each word occupies exactly WIDTH cycles on x.
- Outputs:
  - x and x_valid are decoded from registered state only; no input-to-x combinational path.
  - busy = (state==SHIFT).
- data_in changes while not accepted: ignored. Holding data_valid with no ready: no effect; the producer must hold its word.
- Reset mid-word: the word is abandoned and not counted. x returns to IDLE_BIT in the cycle after the reset edge.
- words_sent: unsigned, wraps 2^CNT_W-1 -> 0 with no flag.

Test Plan:
- Idle: reset, data_valid=0 for 20 cycles -> x=1, x_valid=0, data_ready=1, words_sent=0 throughout.
- Single word: data_in=8'h40 accepted at edge N (MSB_FIRST) -> x = 0,1,0,0,0,0,0,0 in the 8 cycles after N, then 1. words_sent=1 after edge N+7. The downstream detector sees "010".
- Back-to-back: 8'hA5 then 8'h3C, data_valid held high -> 16 contiguous x_valid cycles, bits 10100101 00111100. data_ready is high only in the two last-bit cycles after the first accept. words_sent=2.
- Reset mid-word: accept 8'hFF, assert rst after 3 bits -> in the next cycle x=1, x_valid=0, busy=0, words_sent=0. A new word is accepted normally after rst drops.
- LSB-first: MSB_FIRST=0, data_in=8'h02 -> x = 0,1,0,0,0,0,0,0.
- Wrap: 1024 back-to-back words with CNT_W=10 -> words_sent reads 1023, then 0 after the 1024th word's last-bit edge.
